instruction_fetch: RTL

Fetch stage of the 64-bit ARM (LEGv8-style) pipeline. It holds the program counter, issues in-order word requests to instruction memory through a valid/ready handshake and buffers the returned words with their PCs in a small FIFO. It hands each {pc, instruction} pair to decode, where the instruction word drives the immediate sign-extension and register-read logic. A redirect from execute (taken branch) flushes the buffer and discards stale in-flight responses.

---
 rtl/instruction_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage for a 64-bit LEGv8-style pipeline. Holds the PC,
//               issues in-order word requests to instruction memory, buffers
//               returned words with their PCs in a DEPTH-entry FIFO and
//               presents them to decode. A redirect empties the buffer,
//               reloads the PC and discards every response still in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   imem_req_*         - request channel (valid/ready, 64-bit byte address)
//   imem_resp_*        - in-order response channel, no backpressure
//   redirect_*         - taken-branch redirect from execute
//   if_*               - {pc, instruction} handed to decode (valid/ready)
// ============================================================================
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [63:0] if_pc,
   output logic [31:0] if_instruction
);

   localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [63:0]        pc_q, pc_d;
   logic [63:0]        tail_pc_q, tail_pc_d;
   logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_cnt_w-1:0] count_q, count_d;
   logic [c_cnt_w-1:0] inflight_q, inflight_d;
   logic [c_cnt_w-1:0] drop_q, drop_d;

   logic [63:0]        fifo_pc_q    [DEPTH];
   logic [31:0]        fifo_instr_q [DEPTH];

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   logic [c_cnt_w:0]   w_credit_sum;
   logic               w_room;
   logic               w_nonempty;
   logic               w_req_fire;
   logic               w_resp;
   logic               w_push;
   logic               w_pop;
   logic [63:0]        w_redirect_pc;
   logic               w_unused_redirect_lsbs;

   // Credit counts every outstanding request (stale or not) plus every
   // buffered word, so an accepted response always finds a free entry.
   assign w_credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
   assign w_room       = (w_credit_sum < c_depth);
   assign w_nonempty   = (count_q != '0);

   assign imem_req_valid = !reset && !redirect_valid && w_room;
   assign imem_req_addr  = pc_q;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error; ignoring it
   // keeps the counters from wrapping.
   assign w_resp = !reset && imem_resp_valid && (inflight_q != '0);
   assign w_push = w_resp && !redirect_valid && (drop_q == '0);

   assign if_valid       = !reset && !redirect_valid && w_nonempty;
   assign w_pop          = if_valid && if_ready;
   assign if_pc          = (!reset && w_nonempty) ? fifo_pc_q[rd_ptr_q]    : 64'h0;
   assign if_instruction = (!reset && w_nonempty) ? fifo_instr_q[rd_ptr_q] : 32'h0;

   assign w_redirect_pc          = {redirect_pc[63:2], 2'b00};
   assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d       = pc_q;
      tail_pc_d  = tail_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      drop_d     = drop_q;
      inflight_d = inflight_q + c_cnt_w'(w_req_fire) - c_cnt_w'(w_resp);

      if (redirect_valid) begin
         pc_d      = w_redirect_pc;
         tail_pc_d = w_redirect_pc;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         // Everything still outstanding becomes stale. Stale requests are
         // already part of inflight, so the new drop count is simply what
         // remains outstanding after this cycle's (discarded) response.
         drop_d    = inflight_q - c_cnt_w'(w_resp);
      end else begin
         if (w_req_fire) begin
            pc_d = pc_q + 64'd4;
         end
         if (w_push) begin
            tail_pc_d = tail_pc_q + 64'd4;
            wr_ptr_d  = wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (w_resp && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
         end
         count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         tail_pc_q  <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         tail_pc_q  <= tail_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // Buffer storage needs no reset: count gates every read.
   always_ff @(posedge clock) begin
      if (w_push) begin
         fifo_pc_q[wr_ptr_q]    <= tail_pc_q;
         fifo_instr_q[wr_ptr_q] <= imem_resp_data;
      end
   end

endmodule
`default_nettype wire
